// File: rtl/sat_fuzzer.sv
// sat_fuzzer: self-contained fuzzer and monitor for an iterative 128-bit
// block cipher. It generates pseudo-random key/plaintext pairs with an
// xorshift64 PRNG, or takes operands from the bus when fuzzing is off. It runs
// the 10-round cipher, watches for hangs with a watchdog, and compares every
// new ciphertext against a circular trace of past operations to find output
// collisions. On the first anomaly it latches the culprit operands and halts
// until reset.
//
// Optional feature macro: SAT_FUZZ_FAULT_INJECT_EN
//   defined   : key[7:0]==8'hA5 hangs the cipher (watchdog fires),
//               key[7:0]==8'h5A forces the ciphertext to zero.
//   undefined : no fault logic; the cipher always completes.
//
// Ports:
//   clk             in   single rising-edge clock
//   rst_n           in   synchronous reset, ACTIVE-HIGH despite its name
//   fuzz_en         in   1 = PRNG operands, 0 = bus operands
//   bus_start       in   one-cycle request for a bus operation (IDLE only)
//   bus_state       in   bus plaintext, sampled with bus_start
//   bus_key         in   bus key, sampled with bus_start
//   aes_out         out  last ciphertext
//   aes_out_valid   out  one-cycle pulse when aes_out updates
//   alarm_timeout   out  sticky watchdog alarm
//   alarm_collision out  sticky collision alarm
//   error_key       out  key of the offending operation
//   error_state     out  plaintext of the offending operation
//   error_out       out  ciphertext of the offending operation (0 on timeout)
//
// state | meaning
// IDLE  | wait for fuzz_en or bus_start
// GEN   | four PRNG steps build {state,key}
// START | load cipher, arm watchdog
// RUN   | one cipher round per cycle, watchdog counts down
// SCAN  | compare new result against one trace entry per cycle
// STORE | append operation to trace buffer
// HALT  | anomaly latched, stay until reset

module sat_fuzzer #(
  parameter int WATCHDOG_LIMIT = 50,
  parameter int TRACE_DEPTH    = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fuzz_en,
  input  logic         bus_start,
  input  logic [127:0] bus_state,
  input  logic [127:0] bus_key,
  output logic [127:0] aes_out,
  output logic         aes_out_valid,
  output logic         alarm_timeout,
  output logic         alarm_collision,
  output logic [127:0] error_key,
  output logic [127:0] error_state,
  output logic [127:0] error_out
);

  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int WW = $clog2(WATCHDOG_LIMIT + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GEN   = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] SCAN  = 3'd4;
  localparam logic [2:0] STORE = 3'd5;
  localparam logic [2:0] HALT  = 3'd6;

  localparam logic [63:0]   PRNG_SEED = 64'h9E3779B97F4A7C15;
  localparam logic [PW:0]   FILL_FULL = (PW+1)'(TRACE_DEPTH);
  localparam logic [PW:0]   FILL_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [WW-1:0] WD_LOAD   = WW'(WATCHDOG_LIMIT - 1);
  localparam logic [WW-1:0] WD_ONE    = WW'(1);

  logic [2:0]    st;
  logic [63:0]   prng;
  logic [1:0]    gen_cnt;
  logic [127:0]  op_key;
  logic [127:0]  op_state;
  logic [127:0]  cs;
  logic [127:0]  rk;
  logic [3:0]    rnd;
  logic [WW-1:0] wd_cnt;
  logic [PW:0]   scan_cnt;
  logic [PW:0]   fill;
  logic [PW-1:0] wr_ptr;

  logic [127:0] tr_key   [TRACE_DEPTH];
  logic [127:0] tr_state [TRACE_DEPTH];
  logic [127:0] tr_out   [TRACE_DEPTH];

  // PRNG step; the GEN outputs are the post-step values
  logic [63:0] x1, x2, prng_next;
  assign x1        = prng ^ (prng << 13);
  assign x2        = x1 ^ (x1 >> 7);
  assign prng_next = x2 ^ (x2 << 17);

  // One cipher round from the current registers
  logic [127:0] mix, s_next, rk_next, cipher_res;
  logic         fault_hang, cipher_done;
  assign mix     = cs ^ rk;
  assign s_next  = {mix[114:0], mix[127:115]} + {cs[63:0], cs[127:64]};
  assign rk_next = {rk[126:0], rk[127]} ^ {124'd0, rnd + 4'd1};

`ifdef SAT_FUZZ_FAULT_INJECT_EN
  assign fault_hang = (op_key[7:0] == 8'hA5);
  assign cipher_res = (op_key[7:0] == 8'h5A) ? 128'd0 : s_next;
`else
  assign fault_hang = 1'b0;
  assign cipher_res = s_next;
`endif

  assign cipher_done = (rnd == 4'd9) && !fault_hang;

  // Oldest entry is slot 0 until the buffer fills, then the write pointer
  logic [PW-1:0] scan_base, scan_idx;
  logic          scan_hit;
  assign scan_base = (fill == FILL_FULL) ? wr_ptr : '0;
  assign scan_idx  = scan_base + scan_cnt[PW-1:0];
  assign scan_hit  = (tr_out[scan_idx] == aes_out) &&
                     ((tr_key[scan_idx] != op_key) || (tr_state[scan_idx] != op_state));

  always_ff @(posedge clk) begin
    if (rst_n) begin
      st              <= IDLE;
      prng            <= PRNG_SEED;
      gen_cnt         <= '0;
      op_key          <= '0;
      op_state        <= '0;
      cs              <= '0;
      rk              <= '0;
      rnd             <= '0;
      wd_cnt          <= '0;
      scan_cnt        <= '0;
      fill            <= '0;
      wr_ptr          <= '0;
      aes_out         <= '0;
      aes_out_valid   <= 1'b0;
      alarm_timeout   <= 1'b0;
      alarm_collision <= 1'b0;
      error_key       <= '0;
      error_state     <= '0;
      error_out       <= '0;
    end else begin
      aes_out_valid <= 1'b0;
      case (st)
        IDLE: begin
          if (fuzz_en) begin
            gen_cnt <= '0;
            st      <= GEN;
          end else if (bus_start) begin
            op_key   <= bus_key;
            op_state <= bus_state;
            st       <= START;
          end
        end
        GEN: begin
          prng <= prng_next;
          // shift in: p0 lands in state[127:64], p3 in key[63:0]
          {op_state, op_key} <= {op_state[63:0], op_key, prng_next};
          gen_cnt <= gen_cnt + 2'd1;
          if (gen_cnt == 2'd3) st <= START;
        end
        START: begin
          cs     <= op_state;
          rk     <= op_key;
          rnd    <= '0;
          wd_cnt <= WD_LOAD;
          st     <= RUN;
        end
        RUN: begin
          if (cipher_done) begin
            aes_out       <= cipher_res;
            aes_out_valid <= 1'b1;
            scan_cnt      <= '0;
            st            <= SCAN;
          end else if (wd_cnt == '0) begin
            alarm_timeout <= 1'b1;
            error_key     <= op_key;
            error_state   <= op_state;
            error_out     <= '0;
            st            <= HALT;
          end else begin
            // a hung cipher parks on its last round while the watchdog runs
            if (rnd != 4'd9) begin
              cs  <= s_next;
              rk  <= rk_next;
              rnd <= rnd + 4'd1;
            end
            wd_cnt <= wd_cnt - WD_ONE;
          end
        end
        SCAN: begin
          if (fill == '0) begin
            st <= STORE;
          end else if (scan_hit) begin
            alarm_collision <= 1'b1;
            error_key       <= op_key;
            error_state     <= op_state;
            error_out       <= aes_out;
            st              <= HALT;
          end else if (scan_cnt + FILL_ONE == fill) begin
            st <= STORE;
          end else begin
            scan_cnt <= scan_cnt + FILL_ONE;
          end
        end
        STORE: begin
          wr_ptr <= wr_ptr + PTR_ONE;
          if (fill != FILL_FULL) fill <= fill + FILL_ONE;
          st <= IDLE;
        end
        HALT: st <= HALT;
        default: st <= IDLE;
      endcase
    end
  end

  // Trace storage is plain memory; validity is tracked by fill
  always_ff @(posedge clk) begin
    if (st == STORE) begin
      tr_key[wr_ptr]   <= op_key;
      tr_state[wr_ptr] <= op_state;
      tr_out[wr_ptr]   <= aes_out;
    end
  end

endmodule

// File: tb/tb_sat_fuzzer.sv
module tb_sat_fuzzer;

  localparam int TD = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         fuzz_en = 1'b0;
  logic         bus_start = 1'b0;
  logic [127:0] bus_state = '0;
  logic [127:0] bus_key = '0;
  logic [127:0] aes_out;
  logic         aes_out_valid;
  logic         alarm_timeout;
  logic         alarm_collision;
  logic [127:0] error_key;
  logic [127:0] error_state;
  logic [127:0] error_out;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  sat_fuzzer #(.WATCHDOG_LIMIT(50), .TRACE_DEPTH(TD)) dut (
    .clk(clk), .rst_n(rst_n), .fuzz_en(fuzz_en), .bus_start(bus_start),
    .bus_state(bus_state), .bus_key(bus_key), .aes_out(aes_out),
    .aes_out_valid(aes_out_valid), .alarm_timeout(alarm_timeout),
    .alarm_collision(alarm_collision), .error_key(error_key),
    .error_state(error_state), .error_out(error_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference cipher written from the round equations
  function automatic logic [127:0] ref_cipher(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] s, k, t;
    s = pt;
    k = key;
    for (int i = 0; i < 10; i++) begin
      t = s ^ k;
      s = ((t << 13) | (t >> 115)) + ((s << 64) | (s >> 64));
      k = ((k << 1) | (k >> 127)) ^ 128'(i + 1);
    end
    return s;
  endfunction

  function automatic logic [63:0] xs64(input logic [63:0] v);
    v = v ^ (v << 13);
    v = v ^ (v >> 7);
    v = v ^ (v << 17);
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    fuzz_en = 1'b0;
    bus_start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    bit ok;
    n = 0;
    ok = 0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      if (aes_out_valid) ok = 1;
    end
    check("wait_valid", 128'(ok), 128'd1);
  endtask

  task automatic issue_bus(input logic [127:0] key, input logic [127:0] pt);
    @(negedge clk);
    bus_key = key;
    bus_state = pt;
    bus_start = 1'b1;
    @(negedge clk);
    bus_start = 1'b0;
  endtask

  task automatic bus_op(input logic [127:0] key, input logic [127:0] pt, input string tag);
    int lat;
    issue_bus(key, pt);
    wait_valid(40, lat);
    check({tag, "_latency"}, 128'(lat), 128'd11);
    check({tag, "_out"}, aes_out, ref_cipher(key, pt));
    @(negedge clk);
    check({tag, "_pulse"}, 128'(aes_out_valid), 128'd0);
    repeat (TD + 8) @(negedge clk);
    check({tag, "_alarms"}, {alarm_timeout, alarm_collision}, 128'd0);
  endtask

  initial begin
    logic [127:0] k, s;
    bit seen;

    // reset values
    repeat (5) @(negedge clk);
    check("rst_aes_out", aes_out, 128'd0);
    check("rst_valid", 128'(aes_out_valid), 128'd0);
    check("rst_timeout", 128'(alarm_timeout), 128'd0);
    check("rst_collision", 128'(alarm_collision), 128'd0);
    check("rst_err_key", error_key, 128'd0);
    check("rst_err_state", error_state, 128'd0);
    check("rst_err_out", error_out, 128'd0);
    rst_n = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (aes_out_valid) seen = 1;
    end
    check("idle_no_valid", 128'(seen), 128'd0);

    // single zero operation
    bus_op(128'd0, 128'd0, "bus_zero");

    // random bus operations
    for (int i = 0; i < 8; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      s = {$urandom, $urandom, $urandom, $urandom};
      if (k[7:0] == 8'hA5 || k[7:0] == 8'h5A) k[7:0] = 8'h00;
      bus_op(k, s, "bus_rand");
    end

    // identical repeat is not a collision and is stored twice
    do_reset();
    bus_op(128'h1, 128'h2, "repeat1");
    bus_op(128'h1, 128'h2, "repeat2");
    check("repeat_no_coll", 128'(alarm_collision), 128'd0);

`ifndef SAT_FUZZ_FAULT_INJECT_EN
    begin
      logic [63:0] x, p0, p1, p2, p3;
      int lat, prev_cyc, n_ent, last_scan;
      x = 64'h9E3779B97F4A7C15;
      n_ent = 2;
      last_scan = 0;
      prev_cyc = 0;
      @(negedge clk);
      fuzz_en = 1'b1;
      for (int op = 0; op < 200; op++) begin
        wait_valid(200, lat);
        x = xs64(x); p0 = x;
        x = xs64(x); p1 = x;
        x = xs64(x); p2 = x;
        x = xs64(x); p3 = x;
        check("fuzz_out", aes_out, ref_cipher({p2, p3}, {p0, p1}));
        // period depends on how many entries the previous op scanned
        if (op > 0)
          check("fuzz_period", 128'(cyc - prev_cyc),
                128'(17 + ((last_scan < 1) ? 1 : last_scan)));
        prev_cyc = cyc;
        last_scan = n_ent;
        n_ent = (n_ent + 1 > TD) ? TD : n_ent + 1;
      end
      fuzz_en = 1'b0;
      repeat (TD + 8) @(negedge clk);
      check("fuzz_alarms", {alarm_timeout, alarm_collision}, 128'd0);
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (aes_out_valid) seen = 1;
      end
      check("fuzz_stopped", 128'(seen), 128'd0);
    end
`else
    begin
      int n;
      // watchdog timeout
      do_reset();
      issue_bus(128'hA5, 128'd0);
      n = 0;
      while (n < 100 && !alarm_timeout) begin
        @(negedge clk);
        n++;
      end
      check("timeout_cycle", 128'(n), 128'd51);
      check("timeout_err_key", error_key, 128'hA5);
      check("timeout_err_state", error_state, 128'd0);
      check("timeout_err_out", error_out, 128'd0);
      issue_bus(128'd0, 128'd0);
      seen = 0;
      repeat (30) begin
        @(negedge clk);
        if (aes_out_valid) seen = 1;
      end
      check("halt_ignores_bus", 128'(seen), 128'd0);
      check("halt_timeout_sticky", 128'(alarm_timeout), 128'd1);

      // forced-zero collision
      do_reset();
      bus_op(128'h5A, 128'h1, "coll_first");
    end
`endif

`ifdef SAT_FUZZ_FAULT_INJECT_EN
    begin
      int lat;
      issue_bus(128'h5A, 128'h2);
      wait_valid(40, lat);
      check("coll_out", aes_out, 128'd0);
      check("coll_not_yet", 128'(alarm_collision), 128'd0);
      @(negedge clk);
      check("coll_alarm", 128'(alarm_collision), 128'd1);
      check("coll_err_state", error_state, 128'h2);
      check("coll_err_key", error_key, 128'h5A);
      check("coll_err_out", error_out, 128'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
